// File: rtl/goose_hit_manager.sv
// rtl/goose_hit_manager.sv - per-frame goose/obstacle collision manager
// Accumulates pixel overlaps per frame and sequences hit-stop, invulnerability, lives and game-over.
module goose_hit_manager #(
  parameter int N_OBST         = 3,
  parameter int LIVES          = 3,
  parameter int HITSTOP_FRAMES = 30,
  parameter int INVULN_FRAMES  = 60
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              restart,
  input  logic              goose,
  input  logic [N_OBST-1:0] bean,
  output logic              hit,
  output logic [N_OBST-1:0] hit_id,
  output logic              freeze,
  output logic              invuln,
  output logic [3:0]        lives,
  output logic              game_over
);

  typedef enum logic [1:0] {RUN, HITSTOP, INVULN, OVER} state_t;

  state_t            state, state_n;
  logic [N_OBST-1:0] ovl, ovl_n, ev, hit_id_n;
  logic [7:0]        fcnt, fcnt_n;
  logic [3:0]        lives_n;
  logic              hit_n;

  // This cycle's pixel counts toward the frame even when it is the tick cycle.
  assign ev = ovl | ({N_OBST{goose}} & bean);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      ovl       <= '0;
      fcnt      <= '0;
      lives     <= 4'(LIVES);
      hit       <= 1'b0;
      hit_id    <= '0;
      freeze    <= 1'b0;
      invuln    <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      ovl       <= ovl_n;
      fcnt      <= fcnt_n;
      lives     <= lives_n;
      hit       <= hit_n;
      hit_id    <= hit_id_n;
      freeze    <= (state_n == HITSTOP) || (state_n == OVER);
      invuln    <= (state_n == INVULN);
      game_over <= (state_n == OVER);
    end
  end

  always_comb begin
    state_n  = state;
    ovl_n    = frame_tick ? '0 : ev;
    fcnt_n   = fcnt;
    lives_n  = lives;
    hit_n    = 1'b0;
    hit_id_n = hit_id;
    if (restart) begin
      state_n  = RUN;
      ovl_n    = '0;
      fcnt_n   = '0;
      lives_n  = 4'(LIVES);
      hit_id_n = '0;
    end else if (frame_tick) begin
      case (state)
        RUN: begin
          if (ev != '0) begin
            hit_n    = 1'b1;
            hit_id_n = ev;
            lives_n  = lives - 4'd1;
            if (lives == 4'd1) begin
              state_n = OVER;
            end else begin
              state_n = HITSTOP;
              fcnt_n  = 8'(HITSTOP_FRAMES);
            end
          end
        end
        HITSTOP: begin
          fcnt_n = fcnt - 8'd1;
          if (fcnt == 8'd1) begin
            state_n = INVULN;
            fcnt_n  = 8'(INVULN_FRAMES);
          end
        end
        INVULN: begin
          fcnt_n = fcnt - 8'd1;
          if (fcnt == 8'd1) state_n = RUN;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_goose_hit_manager.sv
// tb/tb_goose_hit_manager.sv - randomized self-checking bench for goose_hit_manager
module tb_goose_hit_manager;

  localparam int N  = 2;
  localparam int LV = 2;
  localparam int HS = 2;
  localparam int IV = 3;

  logic         clk = 1'b0;
  logic         reset, frame_tick, restart, goose;
  logic [N-1:0] bean;
  logic         hit, freeze, invuln, game_over;
  logic [N-1:0] hit_id;
  logic [3:0]   lives;

  int n_pass  = 0;
  int n_check = 0;

  // Reference model: remaining freeze/invuln ticks rather than a state machine.
  int           m_lives, m_freeze_left, m_invuln_left;
  bit           m_over, m_hit;
  logic [N-1:0] m_hid, m_acc;

  goose_hit_manager #(
    .N_OBST(N), .LIVES(LV), .HITSTOP_FRAMES(HS), .INVULN_FRAMES(IV)
  ) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .restart(restart),
    .goose(goose), .bean(bean), .hit(hit), .hit_id(hit_id), .freeze(freeze),
    .invuln(invuln), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_check++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_lives = LV; m_freeze_left = 0; m_invuln_left = 0;
    m_over = 0; m_hit = 0; m_hid = '0; m_acc = '0;
  endtask

  task automatic model_update(input logic ft, input logic rs, input logic g, input logic [N-1:0] b);
    logic [N-1:0] cur, frame_ev;
    cur = g ? b : '0;
    m_hit = 0;
    if (rs) begin
      model_reset();
    end else if (!ft) begin
      m_acc = m_acc | cur;
    end else begin
      frame_ev = m_acc | cur;
      m_acc = '0;
      if (m_over) begin
      end else if (m_freeze_left > 0) begin
        m_freeze_left--;
        if (m_freeze_left == 0) m_invuln_left = IV;
      end else if (m_invuln_left > 0) begin
        m_invuln_left--;
      end else if (frame_ev != '0) begin
        m_hit = 1;
        m_hid = frame_ev;
        m_lives--;
        if (m_lives == 0) m_over = 1;
        else m_freeze_left = HS;
      end
    end
  endtask

  task automatic compare_all();
    check("hit", 8'(hit), 8'(m_hit));
    check("hit_id", 8'(hit_id), 8'(m_hid));
    check("freeze", 8'(freeze), 8'(m_freeze_left > 0 || m_over));
    check("invuln", 8'(invuln), 8'(m_invuln_left > 0));
    check("lives", 8'(lives), 8'(m_lives));
    check("game_over", 8'(game_over), 8'(m_over));
  endtask

  task automatic step(input logic ft, input logic rs, input logic g, input logic [N-1:0] b);
    frame_tick = ft; restart = rs; goose = g; bean = b;
    @(posedge clk);
    model_update(ft, rs, g, b);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; frame_tick = 0; restart = 0; goose = 0; bean = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b0;

    // goose alone never hits
    step(0, 0, 1, 2'b00); step(0, 0, 1, 2'b00); step(1, 0, 1, 2'b00);
    check("no_hit_goose_only", 8'(hit), 8'd0);

    // single overlap mid-frame
    step(0, 0, 1, 2'b10); step(0, 0, 0, 2'b00); step(1, 0, 0, 2'b00);
    check("single_hit", 8'(hit), 8'd1);
    check("single_id", 8'(hit_id), 8'd2);
    check("single_lives", 8'(lives), 8'd1);
    check("single_freeze", 8'(freeze), 8'd1);
    step(0, 0, 0, 2'b00);
    check("hit_one_cycle", 8'(hit), 8'd0);

    // overlaps ignored during hit-stop and invulnerability
    step(0, 0, 1, 2'b01); step(1, 0, 1, 2'b01);
    check("freeze_tick1", 8'(freeze), 8'd1);
    step(0, 0, 1, 2'b11); step(1, 0, 0, 2'b00);
    check("freeze_end", 8'(freeze), 8'd0);
    check("invuln_start", 8'(invuln), 8'd1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 2'b11); step(1, 0, 1, 2'b01);
    end
    check("invuln_end", 8'(invuln), 8'd0);
    check("lives_kept", 8'(lives), 8'd1);

    // simultaneous overlap costs one life
    step(0, 1, 0, 2'b00);
    step(0, 0, 1, 2'b11); step(1, 0, 0, 2'b00);
    check("dual_id", 8'(hit_id), 8'd3);
    check("dual_lives", 8'(lives), 8'd1);
    for (int i = 0; i < HS + IV; i++) step(1, 0, 0, 2'b00);

    // fatal hit with overlap only on the tick cycle
    step(1, 0, 1, 2'b01);
    check("fatal_hit", 8'(hit), 8'd1);
    check("fatal_lives", 8'(lives), 8'd0);
    check("fatal_over", 8'(game_over), 8'd1);
    check("fatal_freeze", 8'(freeze), 8'd1);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 2'b11);
    check("over_hold", 8'(game_over), 8'd1);

    // restart beats a simultaneous tick and overlap
    step(1, 1, 1, 2'b11);
    check("restart_hit", 8'(hit), 8'd0);
    check("restart_lives", 8'(lives), 8'd2);
    check("restart_over", 8'(game_over), 8'd0);

    // asynchronous reset mid hit-stop
    step(0, 0, 1, 2'b01); step(1, 0, 0, 2'b00);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("areset_freeze", 8'(freeze), 8'd0);
    check("areset_lives", 8'(lives), 8'd2);
    check("areset_id", 8'(hit_id), 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      step(logic'($urandom_range(0, 11) == 0), logic'($urandom_range(0, 149) == 0),
           logic'($urandom_range(0, 3) == 0), N'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
